// File: rtl/rob_commit_unit.sv
// rob_commit_unit
//   In-order commit stage: an 8-entry reorder buffer together with the
//   architectural register file (ARF) and register alias table (RAT).
//   Issue allocates entries at the tail in program order, execute writes
//   results back by tag, and the head entry retires into the ARF once its
//   result is present.
//
// Handshake: an allocation is accepted on a rising edge where
//   alloc_valid && alloc_ready; alloc_ready reflects the registered count
//   only, so a commit in the same cycle never frees room for that cycle's
//   allocation. execute_done has no back-pressure: a broadcast is taken or
//   silently ignored in the cycle it is presented.
//
// Ports:
//   clk1, rst                      clock (rising edge), synchronous active-high reset
//   alloc_valid/_dest_reg, in_type allocation request, destination, op type
//   alloc_ready, alloc_tag         ROB not full, tag of the next allocation
//   execute_done, dest_tag, out    result broadcast (tag, value)
//   arf_rd_addr/_data/_tag         combinational ARF / RAT read port
//   commit_valid/_tag/_reg/        one-cycle retire pulse with the retired
//   _value/_type                   entry's registered fields
module rob_commit_unit #(
   parameter int ROB_DEPTH = 8,
   parameter int DATA_W    = 6,
   parameter int TAG_W     = 6,
   parameter int NREG      = 8,
   parameter int REG_W     = 3
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              alloc_valid,
   input  logic [REG_W-1:0]  alloc_dest_reg,
   input  logic [2:0]        in_type,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              execute_done,
   input  logic [TAG_W-1:0]  dest_tag,
   input  logic [DATA_W-1:0] out,
   input  logic [REG_W-1:0]  arf_rd_addr,
   output logic [DATA_W-1:0] arf_rd_data,
   output logic [TAG_W-1:0]  arf_rd_tag,
   output logic              commit_valid,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [REG_W-1:0]  commit_reg,
   output logic [DATA_W-1:0] commit_value,
   output logic [2:0]        commit_type
);

   localparam int IDX_W = $clog2(ROB_DEPTH);
   localparam int CNT_W = $clog2(ROB_DEPTH + 1);
   localparam logic [TAG_W-1:0] L_DEPTH_TAG = TAG_W'(ROB_DEPTH);
   localparam logic [CNT_W-1:0] L_DEPTH_CNT = CNT_W'(ROB_DEPTH);
   localparam logic [IDX_W-1:0] L_LAST_IDX  = IDX_W'(ROB_DEPTH - 1);

   // ROB entry state
   logic [ROB_DEPTH-1:0] r_busy;
   logic [ROB_DEPTH-1:0] r_ready;
   logic [REG_W-1:0]     r_dest  [ROB_DEPTH];
   logic [2:0]           r_type  [ROB_DEPTH];
   logic [DATA_W-1:0]    r_value [ROB_DEPTH];

   logic [IDX_W-1:0]     r_head;
   logic [IDX_W-1:0]     r_tail;
   logic [CNT_W-1:0]     r_count;

   // Architectural state
   logic [DATA_W-1:0]    r_arf [NREG];
   logic [TAG_W-1:0]     r_rat [NREG];

   logic                 r_commit_valid;
   logic [TAG_W-1:0]     r_commit_tag;
   logic [REG_W-1:0]     r_commit_reg;
   logic [DATA_W-1:0]    r_commit_value;
   logic [2:0]           r_commit_type;

   logic                 w_alloc;
   logic                 w_commit;
   logic                 w_wb_ok;
   logic [IDX_W-1:0]     w_wb_idx;
   logic [TAG_W-1:0]     w_head_tag;
   logic [TAG_W-1:0]     w_tail_tag;
   logic [REG_W-1:0]     w_head_reg;
   logic [IDX_W-1:0]     w_head_next;
   logic [IDX_W-1:0]     w_tail_next;

   assign alloc_ready = (r_count != L_DEPTH_CNT);
   assign w_alloc     = alloc_valid && alloc_ready;
   // Commit looks only at pre-edge state, so a result written back at this
   // edge can retire no earlier than the following edge.
   assign w_commit    = r_busy[r_head] && r_ready[r_head];

   assign w_wb_idx    = IDX_W'(dest_tag - TAG_W'(1));
   assign w_wb_ok     = execute_done && (dest_tag != '0) &&
                        (dest_tag <= L_DEPTH_TAG) && r_busy[w_wb_idx];

   assign w_head_tag  = TAG_W'(r_head) + TAG_W'(1);
   assign w_tail_tag  = TAG_W'(r_tail) + TAG_W'(1);
   assign w_head_reg  = r_dest[r_head];
   assign w_head_next = (r_head == L_LAST_IDX) ? '0 : r_head + IDX_W'(1);
   assign w_tail_next = (r_tail == L_LAST_IDX) ? '0 : r_tail + IDX_W'(1);

   assign alloc_tag    = w_tail_tag;
   assign arf_rd_data  = r_arf[arf_rd_addr];
   assign arf_rd_tag   = r_rat[arf_rd_addr];

   assign commit_valid = r_commit_valid;
   assign commit_tag   = r_commit_tag;
   assign commit_reg   = r_commit_reg;
   assign commit_value = r_commit_value;
   assign commit_type  = r_commit_type;

   always_ff @(posedge clk1) begin
      if (rst) begin
         r_busy         <= '0;
         r_ready        <= '0;
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_commit_valid <= 1'b0;
         r_commit_tag   <= '0;
         r_commit_reg   <= '0;
         r_commit_value <= '0;
         r_commit_type  <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            r_dest[i]  <= '0;
            r_type[i]  <= '0;
            r_value[i] <= '0;
         end
         for (int i = 0; i < NREG; i++) begin
            r_arf[i] <= '0;
            r_rat[i] <= '0;
         end
      end else begin
         if (w_wb_ok) begin
            r_value[w_wb_idx] <= out;
            r_ready[w_wb_idx] <= 1'b1;
         end

         r_commit_valid <= w_commit;
         // Placed after the writeback so retiring the head wins over a
         // late overwrite of the same entry in this cycle.
         if (w_commit) begin
            r_arf[w_head_reg] <= r_value[r_head];
            // A younger in-flight producer keeps its RAT mapping.
            if (r_rat[w_head_reg] == w_head_tag) begin
               r_rat[w_head_reg] <= '0;
            end
            r_busy[r_head]  <= 1'b0;
            r_ready[r_head] <= 1'b0;
            r_head          <= w_head_next;
            r_commit_tag    <= w_head_tag;
            r_commit_reg    <= w_head_reg;
            r_commit_value  <= r_value[r_head];
            r_commit_type   <= r_type[r_head];
         end

         // Placed after the commit so a same-register rename overrides the
         // commit's RAT clear.
         if (w_alloc) begin
            r_busy[r_tail]        <= 1'b1;
            r_ready[r_tail]       <= 1'b0;
            r_dest[r_tail]        <= alloc_dest_reg;
            r_type[r_tail]        <= in_type;
            r_rat[alloc_dest_reg] <= w_tail_tag;
            r_tail                <= w_tail_next;
         end

         case ({w_alloc, w_commit})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_rob_commit_unit.sv
module tb_rob_commit_unit;

   logic       clk1;
   logic       rst;
   logic       alloc_valid;
   logic [2:0] alloc_dest_reg;
   logic [2:0] in_type;
   logic       alloc_ready;
   logic [5:0] alloc_tag;
   logic       execute_done;
   logic [5:0] dest_tag;
   logic [5:0] out;
   logic [2:0] arf_rd_addr;
   logic [5:0] arf_rd_data;
   logic [5:0] arf_rd_tag;
   logic       commit_valid;
   logic [5:0] commit_tag;
   logic [2:0] commit_reg;
   logic [5:0] commit_value;
   logic [2:0] commit_type;

   rob_commit_unit dut (
      .clk1           (clk1),
      .rst            (rst),
      .alloc_valid    (alloc_valid),
      .alloc_dest_reg (alloc_dest_reg),
      .in_type        (in_type),
      .alloc_ready    (alloc_ready),
      .alloc_tag      (alloc_tag),
      .execute_done   (execute_done),
      .dest_tag       (dest_tag),
      .out            (out),
      .arf_rd_addr    (arf_rd_addr),
      .arf_rd_data    (arf_rd_data),
      .arf_rd_tag     (arf_rd_tag),
      .commit_valid   (commit_valid),
      .commit_tag     (commit_tag),
      .commit_reg     (commit_reg),
      .commit_value   (commit_value),
      .commit_type    (commit_type)
   );

   // clock / reset
   initial clk1 = 1'b0;
   always #10 clk1 = ~clk1;

   int checks   = 0;
   int failures = 0;

   // expected commit: {tag[17:12], reg[11:9], value[8:3], type[2:0]}
   logic [17:0] exp_q[$];
   logic [5:0]  m_arf [8];
   bit          wb_done [9];
   int          tb_tail;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // Advance one edge and score any commit pulse produced by it.
   task automatic step();
      logic [17:0] e;
      @(posedge clk1);
      #1;
      if (commit_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_commit", {31'd0, commit_valid}, 0);
         end else begin
            e = exp_q.pop_front();
            chk("commit_tag",   {26'd0, commit_tag},   {26'd0, e[17:12]});
            chk("commit_reg",   {29'd0, commit_reg},   {29'd0, e[11:9]});
            chk("commit_value", {26'd0, commit_value}, {26'd0, e[8:3]});
            chk("commit_type",  {29'd0, commit_type},  {29'd0, e[2:0]});
            m_arf[e[11:9]] = e[8:3];
         end
      end
   endtask

   // driver tasks
   task automatic cyc(input bit av, input logic [2:0] areg, input logic [2:0] atype,
                      input logic [5:0] aval, input bit wv, input logic [5:0] wtag,
                      input logic [5:0] wval);
      alloc_valid    = av;
      alloc_dest_reg = areg;
      in_type        = atype;
      execute_done   = wv;
      dest_tag       = wtag;
      out            = wval;
      if (wv && wtag >= 6'd1 && wtag <= 6'd8) wb_done[wtag] = 1'b1;
      if (av && exp_q.size() < 8) begin
         exp_q.push_back({6'(tb_tail), areg, aval, atype});
         wb_done[tb_tail] = 1'b0;
         tb_tail = (tb_tail == 8) ? 1 : tb_tail + 1;
      end
      step();
      alloc_valid  = 1'b0;
      execute_done = 1'b0;
   endtask

   task automatic alloc(input logic [2:0] areg, input logic [2:0] atype, input logic [5:0] aval);
      cyc(1'b1, areg, atype, aval, 1'b0, 6'd0, 6'd0);
   endtask

   task automatic wb(input logic [5:0] t, input logic [5:0] v);
      cyc(1'b0, 3'd0, 3'd0, 6'd0, 1'b1, t, v);
   endtask

   task automatic idle();
      cyc(1'b0, 3'd0, 3'd0, 6'd0, 1'b0, 6'd0, 6'd0);
   endtask

   task automatic rd(input string name, input logic [2:0] r, input logic [5:0] ed,
                     input logic [5:0] et);
      arf_rd_addr = r;
      #1;
      chk({name, "_data"}, {26'd0, arf_rd_data}, {26'd0, ed});
      chk({name, "_tag"},  {26'd0, arf_rd_tag},  {26'd0, et});
   endtask

   task automatic do_reset();
      alloc_valid  = 1'b0;
      execute_done = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      tb_tail = 1;
      for (int i = 0; i < 8; i++) m_arf[i] = '0;
      for (int i = 0; i < 9; i++) wb_done[i] = 1'b0;
   endtask

   // Write back outstanding entries in random order until all retire.
   task automatic drain();
      int budget;
      int i;
      logic [5:0] t;
      budget = 0;
      while (exp_q.size() > 0 && budget < 300) begin
         i = $urandom_range(0, exp_q.size() - 1);
         t = exp_q[i][17:12];
         if (!wb_done[t]) wb(t, exp_q[i][8:3]);
         else idle();
         budget++;
      end
      chk("drain_done", exp_q.size(), 0);
   endtask

   task automatic check_arf(input string name);
      for (int r = 0; r < 8; r++) rd(name, 3'(r), m_arf[r], 6'd0);
   endtask

   initial begin
      rst            = 1'b0;
      alloc_valid    = 1'b0;
      alloc_dest_reg = '0;
      in_type        = '0;
      execute_done   = 1'b0;
      dest_tag       = '0;
      out            = '0;
      arf_rd_addr    = '0;
      tb_tail        = 1;

      // reset state
      do_reset();
      chk("rst_alloc_ready",  {31'd0, alloc_ready},  1);
      chk("rst_alloc_tag",    {26'd0, alloc_tag},    1);
      chk("rst_commit_valid", {31'd0, commit_valid}, 0);
      check_arf("rst_arf");

      // single op
      alloc(3'd3, 3'd2, 6'd13);
      chk("single_alloc_tag", {26'd0, alloc_tag}, 2);
      rd("single_rat", 3'd3, 6'd0, 6'd1);
      wb(6'd1, 6'd13);
      chk("single_no_same_edge", {31'd0, commit_valid}, 0);
      idle();
      chk("single_commit_pulse", {31'd0, commit_valid}, 1);
      idle();
      chk("single_pulse_ends", {31'd0, commit_valid}, 0);
      rd("single_arf", 3'd3, 6'd13, 6'd0);

      // in-order retire with an overwriting second writeback
      do_reset();
      alloc(3'd1, 3'd5, 6'd4);
      alloc(3'd2, 3'd2, 6'd7);
      wb(6'd2, 6'd20);
      chk("ooo_held_0", {31'd0, commit_valid}, 0);
      wb(6'd2, 6'd7);
      chk("ooo_held_1", {31'd0, commit_valid}, 0);
      idle();
      chk("ooo_held_2", {31'd0, commit_valid}, 0);
      wb(6'd1, 6'd4);
      idle();
      chk("inorder_first", {26'd0, commit_tag}, 1);
      idle();
      chk("inorder_second", {26'd0, commit_tag}, 2);
      rd("inorder_r2", 3'd2, 6'd7, 6'd0);

      // RAT rename: older commit must not clear a younger mapping
      do_reset();
      alloc(3'd4, 3'd4, 6'd33);
      alloc(3'd4, 3'd3, 6'd44);
      rd("rename_rat", 3'd4, 6'd0, 6'd2);
      wb(6'd1, 6'd33);
      idle();
      rd("rename_keep", 3'd4, 6'd33, 6'd2);
      wb(6'd2, 6'd44);
      idle();
      rd("rename_clear", 3'd4, 6'd44, 6'd0);

      // alloc and commit to the same register in one cycle
      do_reset();
      alloc(3'd5, 3'd1, 6'd10);
      wb(6'd1, 6'd10);
      alloc(3'd5, 3'd2, 6'd11);
      rd("samereg", 3'd5, 6'd10, 6'd2);
      wb(6'd2, 6'd11);
      idle();
      rd("samereg_done", 3'd5, 6'd11, 6'd0);

      // full / wrap
      do_reset();
      for (int i = 0; i < 8; i++)
         alloc(3'(i), 3'((i % 5) + 1), 6'($urandom_range(0, 63)));
      chk("full_not_ready", {31'd0, alloc_ready}, 0);
      chk("full_tag_wrap",  {26'd0, alloc_tag},   1);
      alloc(3'd3, 3'd1, 6'd9);
      chk("full_ignored", {31'd0, alloc_ready}, 0);
      wb(6'd1, exp_q[0][8:3]);
      // commit of tag 1 coincides with this request; the full ROB rejects it
      alloc(3'd6, 3'd4, 6'd50);
      chk("full_commit_pulse", {31'd0, commit_valid}, 1);
      chk("wrap_ready", {31'd0, alloc_ready}, 1);
      chk("wrap_tag",   {26'd0, alloc_tag},   1);
      drain();
      check_arf("full_arf");

      // invalid writebacks and mid-stream reset
      do_reset();
      wb(6'd0, 6'd5);
      chk("wb_tag0", {31'd0, commit_valid}, 0);
      wb(6'd9, 6'd5);
      chk("wb_tag9", {31'd0, commit_valid}, 0);
      wb(6'd3, 6'd5);
      idle();
      chk("wb_nonbusy", {31'd0, commit_valid}, 0);
      chk("invalid_ready", {31'd0, alloc_ready}, 1);
      chk("invalid_tag",   {26'd0, alloc_tag},   1);
      alloc(3'd6, 3'd1, 6'd21);
      wb(6'd2, 6'd50);
      alloc(3'd7, 3'd2, 6'd22);
      wb(6'd1, 6'd21);
      idle();
      chk("nb_commit1", {31'd0, commit_valid}, 1);
      idle();
      chk("nb_tag2_not_ready", {31'd0, commit_valid}, 0);
      wb(6'd2, 6'd22);
      do_reset();
      chk("midrst_commit", {31'd0, commit_valid}, 0);
      chk("midrst_tag",    {26'd0, alloc_tag},    1);
      rd("midrst_r7", 3'd7, 6'd0, 6'd0);
      rd("midrst_r6", 3'd6, 6'd0, 6'd0);
      idle();
      chk("midrst_quiet", {31'd0, commit_valid}, 0);

      // random traffic
      do_reset();
      for (int n = 0; n < 120; n++) begin
         bit         av;
         bit         wv;
         int         i;
         logic [5:0] t;
         logic [5:0] v;
         av = 1'($urandom_range(0, 1));
         wv = 1'b0;
         t  = '0;
         v  = '0;
         if (exp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            i = $urandom_range(0, exp_q.size() - 1);
            t = exp_q[i][17:12];
            v = exp_q[i][8:3];
            wv = !wb_done[t];
         end
         cyc(av, 3'($urandom_range(0, 7)), 3'($urandom_range(1, 5)),
             6'($urandom_range(0, 63)), wv, t, v);
      end
      drain();
      check_arf("rand_arf");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- In-order commit stage of the Tomasulo core: an 8-entry reorder buffer (ROB) plus the architectural register file (ARF) and register alias table (RAT).
- Issue allocates ROB entries in program order.
- Execute broadcasts results as (tag, value).
- The unit retires the head entry into the ARF once its result is present, and clears the RAT mapping when appropriate.

Parameters:
- ROB_DEPTH, 8, number of ROB entries; tags are 1..ROB_DEPTH.
- DATA_W, 6, result/register value width.
- TAG_W, 6, tag width; tag 0 means "no producer".
- NREG, 8, architectural register count.
- REG_W, 3, register index width.

Ports:
- clk1  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  issue requests a ROB entry this cycle.
- alloc_dest_reg  in  REG_W  destination register of the issuing instruction.
- in_type  in  3  instruction type of the issuing instruction (1 load, 2 add, 3 sub, 4 mul, 5 div), stored with the entry.
- alloc_ready  out  1  ROB not full.
- alloc_tag  out  TAG_W  tag the next allocation receives (tail index + 1).
- execute_done  in  1  result broadcast valid this cycle.
- dest_tag  in  TAG_W  tag of the broadcast result.
- out  in  DATA_W  broadcast result value.
- arf_rd_addr  in  REG_W  register read address.
- arf_rd_data  out  DATA_W  ARF value at arf_rd_addr (combinational).
- arf_rd_tag  out  TAG_W  RAT entry at arf_rd_addr; 0 = value in ARF is current.
- commit_valid  out  1  one-cycle pulse, an entry retired.
- commit_tag  out  TAG_W  tag of the retired entry.
- commit_reg  out  REG_W  destination register written.
- commit_value  out  DATA_W  value written.
- commit_type  out  3  in_type of the retired entry.

Behaviour:
- State per entry: busy, ready, dest_reg, type, value. Pointers: head and tail (0..ROB_DEPTH-1) and count (0..ROB_DEPTH).
- Reset, on a clk1 edge with rst=1:
  - head=tail=count=0; all busy/ready cleared.
  - ARF and RAT all 0.
  - commit_* outputs 0, alloc_ready=1, alloc_tag=1.
  - rst overrides every other input in that cycle; in-flight entries are discarded.
- alloc_ready = (count != ROB_DEPTH); it is combinational from the registered count.
- Allocation, when alloc_valid and alloc_ready:
  - entry[tail] gets busy=1, ready=0, dest_reg, type.
  - RAT[alloc_dest_reg] = tail+1.
  - tail advances with wrap: index 7 goes to 0, so tags cycle 8 -> 1.
  - alloc_valid while full is ignored, with no state change.
- Writeback, when execute_done:
  - Entry index = dest_tag-1; it gets value=out, ready=1.
  - Ignored if dest_tag is 0, dest_tag > ROB_DEPTH, or the entry is not busy.
  - A second writeback to an already-ready entry overwrites its value.
- Commit, at most one per cycle:
  - Condition: entry[head] busy and ready at the start of the cycle.
  - Action at that edge:
    - ARF[dest_reg] = value.
    - Clear RAT[dest_reg] to 0 only if it still equals head+1.
    - Clear busy/ready; head advances with wrap.
    - commit_valid=1 with tag/reg/value/type registered for exactly one cycle; otherwise commit_valid=0 and the other commit_* outputs hold their last values.
  - Latency: writeback at edge N makes the entry ready; the earliest commit is edge N+1 (commit_valid visible after N+1). A writeback never commits at the same edge.
- Simultaneous events in one cycle:
  - alloc + commit: count unchanged. alloc_ready uses the pre-edge count, so a full ROB rejects allocation even if a commit happens that cycle.
  - alloc and commit to the same register: the allocation's RAT write wins.
  - alloc + writeback to a different entry: both take effect.
- Out-of-order writebacks are held until all older entries commit. A ready entry behind a non-ready head waits.
- Arithmetic: no overflow handling; values are stored as given (DATA_W bits).

Test Plan:
- Reset: assert rst one cycle → alloc_ready=1, alloc_tag=1, commit_valid=0, arf_rd_data=0 and arf_rd_tag=0 for every register.
- Single op:
  - Allocate reg 3, type 2 → alloc_tag becomes 2 and arf_rd_tag(3)=1.
  - Writeback tag 1 value 13 → next edge commit_valid=1, commit_reg=3, commit_value=13, commit_type=2.
  - Afterwards ARF[3]=13 and RAT[3]=0.
- In-order retire:
  - Allocate tags 1 (reg 1, type 5) and 2 (reg 2, type 2); writeback tag 2 value 7 first → no commit.
  - Writeback tag 1 value 4 → tag 1 commits, then tag 2 on the next edge with value 7.
- RAT rename: allocate tag 1 and tag 2 both to reg 4; commit tag 1 → ARF[4] updated, RAT[4] remains 2; commit tag 2 → RAT[4]=0.
- Full/wrap:
  - Allocate 8 entries → alloc_ready=0; a 9th alloc_valid is ignored.
  - Writeback and commit tag 1 → alloc_ready=1 and alloc_tag=1 (wrapped).
- Invalid writebacks: dest_tag 0, 9, or a non-busy tag → no state change, no commit; mid-stream rst clears all entries and commit_valid stays 0.
